// File: rtl/mac_dot_ctrl.sv
// Fixed-length dot-product sequencer: clears the MAC, feeds len_p operand pairs,
// then parks the final sum in an output register with its own ready/valid handshake.
module mac_dot_ctrl #(
    parameter int unsigned int_in_p   = 1,
    parameter int unsigned frac_in_p  = 11,
    parameter int unsigned int_out_p  = 10,
    parameter int unsigned frac_out_p = 22,
    parameter int unsigned len_p      = 4
) (
    input  logic                              clk_i,
    input  logic                              reset_i,

    input  logic [int_in_p+frac_in_p-1:0]     a_i,
    input  logic [int_in_p+frac_in_p-1:0]     b_i,
    input  logic                              valid_i,
    output logic                              ready_o,

    output logic [int_out_p+frac_out_p-1:0]   data_o,
    output logic                              valid_o,
    input  logic                              ready_i,

    output logic                              mac_reset_o,
    output logic [int_in_p+frac_in_p-1:0]     mac_a_o,
    output logic [int_in_p+frac_in_p-1:0]     mac_b_o,
    output logic                              mac_valid_o,
    input  logic                              mac_ready_i,
    input  logic                              mac_valid_i,
    input  logic [int_out_p+frac_out_p-1:0]   mac_data_i,
    output logic                              mac_ready_o
);

    localparam int unsigned WOut = int_out_p + frac_out_p;
    localparam int unsigned CntW = (len_p > 1) ? $clog2(len_p) : 1;
    localparam logic [CntW-1:0] CntLast = CntW'(len_p - 1);

    typedef enum logic [1:0] {
        StClear,
        StFeed,
        StDrain
    } state_e;

    state_e            state_q, state_d;
    logic [CntW-1:0]   cnt_q, cnt_d;
    logic              valid_q, valid_d;
    logic [WOut-1:0]   data_q, data_d;

    logic              in_hs;
    logic              capture;

    // MAC valid is informational only; the sum is sampled a fixed cycle after the last handshake.
    logic              unused_mac_valid;
    assign unused_mac_valid = mac_valid_i;

    always_comb begin
        in_hs   = (state_q == StFeed) && valid_i && mac_ready_i;
        capture = (state_q == StDrain) && (!valid_q || ready_i);
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        valid_d = valid_q;
        data_d  = data_q;

        unique case (state_q)
            StClear: begin
                state_d = StFeed;
                cnt_d   = '0;
            end
            StFeed: begin
                if (in_hs) begin
                    if (cnt_q == CntLast) begin
                        state_d = StDrain;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end
            StDrain: begin
                if (capture) begin
                    state_d = StClear;
                end
            end
            default: begin
                state_d = StClear;
                cnt_d   = '0;
            end
        endcase

        // A fresh capture wins over consumption of the previous result.
        if (valid_q && ready_i) begin
            valid_d = 1'b0;
        end
        if (capture) begin
            valid_d = 1'b1;
            data_d  = mac_data_i;
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q <= StClear;
            cnt_q   <= '0;
            valid_q <= 1'b0;
            data_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            valid_q <= valid_d;
            data_q  <= data_d;
        end
    end

    // Gate with reset so handshakes stay quiet while the state register is still undefined.
    assign ready_o     = !reset_i && (state_q == StFeed) && mac_ready_i;
    assign mac_valid_o = !reset_i && (state_q == StFeed) && valid_i;
    assign mac_reset_o = reset_i || (state_q == StClear);
    assign mac_a_o     = a_i;
    assign mac_b_o     = b_i;
    assign mac_ready_o = 1'b1;
    assign valid_o     = valid_q;
    assign data_o      = data_q;

endmodule

// File: tb/tb_mac_dot_ctrl.sv
// Directed bench for mac_dot_ctrl with a behavioural Q1.11 x Q1.11 -> Q10.22 MAC model.
module tb_mac_dot_ctrl;

    logic        clk = 1'b0;
    logic        reset_i;
    logic [11:0] a_i, b_i;
    logic        valid_i;
    logic        ready_o;
    logic [31:0] data_o;
    logic        valid_o;
    logic        ready_i;
    logic        mac_reset_o;
    logic [11:0] mac_a_o, mac_b_o;
    logic        mac_valid_o;
    logic        mac_ready_i;
    logic        mac_valid_i;
    logic [31:0] mac_data_i;
    logic        mac_ready_o;

    always #5 clk = ~clk;

    mac_dot_ctrl dut (
        .clk_i       (clk),
        .reset_i     (reset_i),
        .a_i         (a_i),
        .b_i         (b_i),
        .valid_i     (valid_i),
        .ready_o     (ready_o),
        .data_o      (data_o),
        .valid_o     (valid_o),
        .ready_i     (ready_i),
        .mac_reset_o (mac_reset_o),
        .mac_a_o     (mac_a_o),
        .mac_b_o     (mac_b_o),
        .mac_valid_o (mac_valid_o),
        .mac_ready_i (mac_ready_i),
        .mac_valid_i (mac_valid_i),
        .mac_data_i  (mac_data_i),
        .mac_ready_o (mac_ready_o)
    );

    // MAC model: signed product, sign-extended, accumulated modulo 2^32.
    logic signed [23:0] prod;
    logic [31:0]        acc;
    assign prod        = $signed(mac_a_o) * $signed(mac_b_o);
    assign mac_data_i  = acc;
    assign mac_ready_i = 1'b1;

    always_ff @(posedge clk) begin
        if (mac_reset_o) begin
            acc         <= '0;
            mac_valid_i <= 1'b0;
        end else begin
            mac_valid_i <= mac_valid_o && mac_ready_i;
            if (mac_valid_o && mac_ready_i) acc <= acc + {{8{prod[23]}}, prod};
        end
    end

    typedef struct packed {
        logic [3:0][11:0] a;
        logic [3:0][11:0] b;
        int               gap;      // idle cycles inserted after element 1
        logic [31:0]      exp_data;
        int               exp_lat;  // cycles from first accept to valid_o
    } vec_t;

    vec_t vecs[5];
    int   n_checks = 0;
    int   n_fail   = 0;
    int   cyc      = 0;

    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic send_pair(input logic [11:0] a, input logic [11:0] b, output int acc_cyc);
        int n;
        a_i     = a;
        b_i     = b;
        valid_i = 1'b1;
        n = 0;
        while (!ready_o && n < 50) begin
            tick();
            n++;
        end
        if (!ready_o) begin
            n_checks++;
            n_fail++;
            $display("FAIL accept_timeout: ready_o stayed 0, expected 1");
        end
        acc_cyc = cyc;
        tick();
        valid_i = 1'b0;
    endtask

    task automatic wait_valid(output bit ok);
        int n;
        n = 0;
        while (!valid_o && n < 50) begin
            tick();
            n++;
        end
        ok = valid_o;
        if (!ok) begin
            n_checks++;
            n_fail++;
            $display("FAIL result_timeout: valid_o stayed 0, expected 1");
        end
    endtask

    initial begin
        int  t0, tdum;
        bit  ok;

        vecs[0] = '{a: {12'h400, 12'h400, 12'h400, 12'h400}, b: {12'h400, 12'h400, 12'h400, 12'h400},
                    gap: 0, exp_data: 32'h0040_0000, exp_lat: 5};
        // Element 0 is the rightmost entry: (0x400,0xC00),(0x400,0x400),(0xC00,0xC00),(0x200,0x400)
        vecs[1] = '{a: {12'h200, 12'hC00, 12'h400, 12'h400}, b: {12'h400, 12'hC00, 12'h400, 12'hC00},
                    gap: 0, exp_data: 32'h0018_0000, exp_lat: 5};
        vecs[2] = '{a: {12'h400, 12'h400, 12'h400, 12'h400}, b: {12'h400, 12'h400, 12'h400, 12'h400},
                    gap: 3, exp_data: 32'h0040_0000, exp_lat: 8};
        vecs[3] = '{a: {12'h800, 12'h800, 12'h800, 12'h800}, b: {12'h800, 12'h800, 12'h800, 12'h800},
                    gap: 0, exp_data: 32'h0100_0000, exp_lat: 5};
        vecs[4] = '{a: {12'h7FF, 12'h7FF, 12'h7FF, 12'h7FF}, b: {12'h800, 12'h800, 12'h800, 12'h800},
                    gap: 0, exp_data: 32'hFF00_2000, exp_lat: 5};

        reset_i = 1'b1;
        valid_i = 1'b1;
        ready_i = 1'b1;
        a_i     = 12'h400;
        b_i     = 12'h400;

        // Reset behaviour
        repeat (3) tick();
        check("rst_valid_o", 32'(valid_o), 32'd0);
        check("rst_data_o", data_o, 32'd0);
        check("rst_mac_reset_o", 32'(mac_reset_o), 32'd1);
        check("rst_ready_o", 32'(ready_o), 32'd0);
        check("rst_mac_valid_o", 32'(mac_valid_o), 32'd0);
        check("rst_mac_ready_o", 32'(mac_ready_o), 32'd1);
        valid_i = 1'b0;
        reset_i = 1'b0;
        check("clear_ready_o", 32'(ready_o), 32'd0);
        check("clear_mac_reset_o", 32'(mac_reset_o), 32'd1);
        tick();
        check("feed_ready_o", 32'(ready_o), 32'd1);
        check("feed_mac_reset_o", 32'(mac_reset_o), 32'd0);

        // Table-driven vectors with ready_i held high
        for (int v = 0; v < 5; v++) begin
            for (int e = 0; e < 4; e++) begin
                send_pair(vecs[v].a[e], vecs[v].b[e], tdum);
                if (e == 0) t0 = tdum;
                if (e == 1) repeat (vecs[v].gap) tick();
            end
            wait_valid(ok);
            if (ok) begin
                check($sformatf("vec%0d_data", v), data_o, vecs[v].exp_data);
                check($sformatf("vec%0d_latency", v), 32'(cyc - t0), 32'(vecs[v].exp_lat));
                check($sformatf("vec%0d_clear_ready", v), 32'(ready_o), 32'd0);
                tick();
                check($sformatf("vec%0d_valid_drop", v), 32'(valid_o), 32'd0);
            end
        end

        // Backpressure: two vectors arrive while the consumer is stalled
        ready_i = 1'b0;
        for (int e = 0; e < 4; e++) send_pair(vecs[0].a[e], vecs[0].b[e], tdum);
        for (int e = 0; e < 4; e++) send_pair(vecs[1].a[e], vecs[1].b[e], tdum);
        valid_i = 1'b1;
        repeat (3) tick();
        check("bp_valid_held", 32'(valid_o), 32'd1);
        check("bp_data_held", data_o, 32'h0040_0000);
        check("bp_drain_ready", 32'(ready_o), 32'd0);
        check("bp_no_mac_valid", 32'(mac_valid_o), 32'd0);
        valid_i = 1'b0;
        ready_i = 1'b1;
        tick();
        check("bp_second_valid", 32'(valid_o), 32'd1);
        check("bp_second_data", data_o, 32'h0018_0000);
        check("bp_clear_ready", 32'(ready_o), 32'd0);
        tick();
        check("bp_consumed", 32'(valid_o), 32'd0);
        check("bp_feed_ready", 32'(ready_o), 32'd1);

        // Reset mid-vector discards the partial sum
        for (int e = 0; e < 2; e++) send_pair(12'h400, 12'h400, tdum);
        reset_i = 1'b1;
        tick();
        reset_i = 1'b0;
        check("midrst_data_o", data_o, 32'd0);
        check("midrst_valid_o", 32'(valid_o), 32'd0);
        for (int e = 0; e < 4; e++) begin
            send_pair(12'h400, 12'h400, tdum);
            if (e == 0) t0 = tdum;
        end
        wait_valid(ok);
        if (ok) begin
            check("midrst_result", data_o, 32'h0040_0000);
            check("midrst_latency", 32'(cyc - t0), 32'd5);
        end
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
